// File: rtl/encoder_round_scheduler.sv
// rtl/encoder_round_scheduler.sv - stage/round sequencer for the matrix-encoder datapaths
module encoder_round_scheduler #(
   parameter int NUM_STAGES = 5,
   parameter int NUM_ROUNDS = 24,
   parameter int ROUND_W    = 5,
   parameter int SEL_W      = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_clear,
   input  logic [NUM_STAGES-1:0] i_stage_done,
   output logic [NUM_STAGES-1:0] o_stage_start,
   output logic [SEL_W-1:0]      o_stage_sel,
   output logic [ROUND_W-1:0]    o_round_idx,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int                 WD_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]    WD_MAX     = WD_W'(TIMEOUT);
   localparam logic [SEL_W-1:0]   LAST_STAGE = SEL_W'(NUM_STAGES - 1);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_FINISH,
      S_ERR
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SEL_W-1:0]      r_stage;
   logic [SEL_W-1:0]      w_stage_nxt;
   logic [ROUND_W-1:0]    r_round;
   logic [ROUND_W-1:0]    w_round_nxt;
   logic [WD_W-1:0]       r_wdog;
   logic [WD_W-1:0]       w_wdog_nxt;
   logic [NUM_STAGES-1:0] w_stage_onehot;

   // the stage that currently owns the line buffer, as a one-hot handshake vector
   assign w_stage_onehot = NUM_STAGES'(1) << r_stage;

   // state and sequencing registers; reset drops every output through the decoded state
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_stage <= '0;
         r_round <= '0;
         r_wdog  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_round <= w_round_nxt;
         r_wdog  <= w_wdog_nxt;
      end
   end

   // next-state logic; outputs are decoded only from registered state, never from inputs
   always_comb begin
      w_state_nxt   = r_state;
      w_stage_nxt   = r_stage;
      w_round_nxt   = r_round;
      w_wdog_nxt    = r_wdog;
      o_stage_start = '0;
      o_stage_sel   = '0;
      o_round_idx   = r_round;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_error       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_ISSUE;
               w_stage_nxt = '0;
               w_round_nxt = '0;
            end
         end
         S_ISSUE: begin
            o_stage_start = w_stage_onehot;
            o_stage_sel   = r_stage;
            o_busy        = 1'b1;
            w_wdog_nxt    = '0;
            // a done before the stage has even seen its start is a protocol violation
            w_state_nxt   = (|i_stage_done) ? S_ERR : S_WAIT;
         end
         S_WAIT: begin
            o_stage_sel = r_stage;
            o_busy      = 1'b1;
            if (i_stage_done == w_stage_onehot) begin
               w_state_nxt = S_NEXT;
            end else if (|(i_stage_done & ~w_stage_onehot)) begin
               w_state_nxt = S_ERR;
            end else if (r_wdog == WD_MAX) begin
               w_state_nxt = S_ERR;
            end else begin
               w_wdog_nxt = r_wdog + WD_W'(1);
            end
         end
         S_NEXT: begin
            o_stage_sel = r_stage;
            o_busy      = 1'b1;
            if (r_stage != LAST_STAGE) begin
               w_stage_nxt = r_stage + SEL_W'(1);
               w_state_nxt = S_ISSUE;
            end else if (r_round != LAST_ROUND) begin
               w_stage_nxt = '0;
               w_round_nxt = r_round + ROUND_W'(1);
               w_state_nxt = S_ISSUE;
            end else begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_ERR: begin
            // stage and round registers are left untouched so the fault point stays visible
            o_error     = 1'b1;
            o_stage_sel = r_stage;
            if (i_clear) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_encoder_round_scheduler.sv
// tb/tb_encoder_round_scheduler.sv - directed bench with a cycle-timeline model for encoder_round_scheduler
module tb_encoder_round_scheduler;
   localparam int NS = 5;
   localparam int NR = 2;
   localparam int TO = 8;
   localparam int RW = 5;
   localparam int SW = 3;
   localparam int N  = 1024;

   localparam int FK_NONE    = 0;
   localparam int FK_TIMEOUT = 1;
   localparam int FK_WRONG   = 2;
   localparam int FK_EARLY   = 3;
   localparam int FK_RESET   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          clear = 1'b0;
   logic [NS-1:0] stage_done = '0;
   logic [NS-1:0] stage_start;
   logic [SW-1:0] stage_sel;
   logic [RW-1:0] round_idx;
   logic          busy;
   logic          done;
   logic          error;

   encoder_round_scheduler #(
      .NUM_STAGES(NS), .NUM_ROUNDS(NR), .ROUND_W(RW), .SEL_W(SW), .TIMEOUT(TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
      .i_stage_done(stage_done), .o_stage_start(stage_start), .o_stage_sel(stage_sel),
      .o_round_idx(round_idx), .o_busy(busy), .o_done(done), .o_error(error)
   );

   always #5 clk = ~clk;

   // expected outputs per cycle
   logic [NS-1:0] e_start [N];
   logic [SW-1:0] e_sel   [N];
   logic [RW-1:0] e_round [N];
   logic          e_busy  [N];
   logic          e_done  [N];
   logic          e_err   [N];
   // stimulus per cycle
   logic          d_start [N];
   logic          d_clear [N];
   logic          d_rst   [N];
   logic          d_drop  [N];
   logic [NS-1:0] d_done  [N];
   // observed outputs per cycle
   logic [NS-1:0] ob_start [N];
   logic [SW-1:0] ob_sel   [N];
   logic [RW-1:0] ob_round [N];
   logic          ob_busy  [N];
   logic          ob_done  [N];
   logic          ob_err   [N];

   int   total = 0;
   int   bad = 0;
   int   cur = 0;
   int   mcyc = 0;
   int   m_round = 0;
   logic running = 1'b0;
   int   t1, t2, t3, t5, t6;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cur, act, exp);
      end
   endtask

   task automatic put(input int c, input logic [NS-1:0] st, input int sel, input int rnd,
                      input logic b, input logic dn, input logic er);
      e_start[c] = st;
      e_sel[c]   = SW'(sel);
      e_round[c] = RW'(rnd);
      e_busy[c]  = b;
      e_done[c]  = dn;
      e_err[c]   = er;
   endtask

   function automatic int lat(input int mode, input int k);
      if (mode == 0) return 1;
      case (k % 3)
         0:       return 1;
         1:       return 4;
         default: return 9;
      endcase
   endfunction

   task automatic plan_idle(input int n);
      for (int j = 0; j < n; j++) begin
         put(mcyc, '0, 0, m_round, 1'b0, 1'b0, 1'b0);
         mcyc++;
      end
   endtask

   // one encode run: start cycle, ISSUE / d WAIT / NEXT per stage, FINISH; optional fault at (fr, fs)
   task automatic plan_run(input int mode, input int fk, input int fr, input int fs,
                           input logic [NS-1:0] fpat, input int foff,
                           input bit hold_fin, input bit busy_starts);
      int c, iss, n, d, k;
      c = mcyc;
      k = 0;
      put(c, '0, 0, m_round, 1'b0, 1'b0, 1'b0);
      d_start[c] = 1'b1;
      c++;
      for (int r = 0; r < NR; r++) begin
         for (int s = 0; s < NS; s++) begin
            iss = c;
            if (fk == FK_RESET && r == fr && s == fs) begin
               put(c, '0, 0, 0, 1'b0, 1'b0, 1'b0);
               d_drop[c] = 1'b1;
               c++;
               for (int j = 0; j < 2; j++) begin
                  put(c, '0, 0, 0, 1'b0, 1'b0, 1'b0);
                  d_rst[c] = 1'b0;
                  c++;
               end
               put(c, '0, 0, 0, 1'b0, 1'b0, 1'b0);
               c++;
               m_round = 0;
               mcyc = c;
               return;
            end
            put(c, NS'(1 << s), s, r, 1'b1, 1'b0, 1'b0);
            c++;
            if (fk != FK_NONE && r == fr && s == fs) begin
               n = 0;
               if (fk == FK_TIMEOUT) n = TO + 1;
               if (fk == FK_WRONG) begin
                  n = foff;
                  d_done[iss + foff] = fpat;
               end
               if (fk == FK_EARLY) d_done[iss] = fpat;
               for (int j = 0; j < n; j++) begin
                  put(c, '0, s, r, 1'b1, 1'b0, 1'b0);
                  c++;
               end
               for (int j = 0; j < 4; j++) begin
                  put(c, '0, s, r, 1'b0, 1'b0, 1'b1);
                  if (j == 1) d_start[c] = 1'b1;
                  if (j == 3) d_clear[c] = 1'b1;
                  c++;
               end
               m_round = r;
               mcyc = c;
               return;
            end
            d = lat(mode, k);
            k++;
            for (int j = 0; j < d; j++) begin
               put(c, '0, s, r, 1'b1, 1'b0, 1'b0);
               if (busy_starts && $urandom_range(0, 2) == 0) begin
                  d_start[c] = 1'b1;
                  d_clear[c] = 1'b1;
               end
               c++;
            end
            d_done[c - 1] = NS'(1 << s);
            put(c, '0, s, r, 1'b1, 1'b0, 1'b0);
            c++;
         end
      end
      put(c, '0, 0, NR - 1, 1'b0, 1'b1, 1'b0);
      if (hold_fin) d_start[c] = 1'b1;
      c++;
      m_round = NR - 1;
      mcyc = c;
   endtask

   // per-cycle comparison of every output against the timeline
   always @(negedge clk) begin
      if (running) begin
         check("stage_start", 32'(stage_start), 32'(e_start[cur]));
         check("stage_sel",   32'(stage_sel),   32'(e_sel[cur]));
         check("round_idx",   32'(round_idx),   32'(e_round[cur]));
         check("busy",        32'(busy),        32'(e_busy[cur]));
         check("done",        32'(done),        32'(e_done[cur]));
         check("error",       32'(error),       32'(e_err[cur]));
         ob_start[cur] = stage_start;
         ob_sel[cur]   = stage_sel;
         ob_round[cur] = round_idx;
         ob_busy[cur]  = busy;
         ob_done[cur]  = done;
         ob_err[cur]   = error;
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         d_start[i] = 1'b0; d_clear[i] = 1'b0; d_rst[i] = 1'b1; d_drop[i] = 1'b0; d_done[i] = '0;
         put(i, '0, 0, 0, 1'b0, 1'b0, 1'b0);
         ob_start[i] = '0; ob_sel[i] = '0; ob_round[i] = '0;
         ob_busy[i] = 1'b0; ob_done[i] = 1'b0; ob_err[i] = 1'b0;
      end

      plan_idle(3);
      t1 = mcyc; plan_run(0, FK_NONE, 0, 0, '0, 0, 1'b0, 1'b0);
      plan_idle(2);
      t2 = mcyc; plan_run(1, FK_NONE, 0, 0, '0, 0, 1'b0, 1'b0);
      plan_idle(2);
      t3 = mcyc; plan_run(0, FK_TIMEOUT, 0, 2, '0, 0, 1'b0, 1'b0);
      plan_idle(2);
      plan_run(0, FK_WRONG, 0, 1, 5'b01000, 2, 1'b0, 1'b0);
      plan_idle(2);
      plan_run(0, FK_WRONG, 0, 1, 5'b00011, 1, 1'b0, 1'b0);
      plan_idle(2);
      plan_run(0, FK_EARLY, 1, 2, 5'b00100, 0, 1'b0, 1'b0);
      plan_idle(2);
      t5 = mcyc; plan_run(0, FK_NONE, 0, 0, '0, 0, 1'b1, 1'b1);
      plan_run(0, FK_NONE, 0, 0, '0, 0, 1'b0, 1'b0);
      plan_idle(2);
      plan_run(0, FK_RESET, 1, 3, '0, 0, 1'b0, 1'b0);
      plan_idle(2);
      t6 = mcyc; plan_run(0, FK_NONE, 0, 0, '0, 0, 1'b0, 1'b0);
      plan_idle(3);

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stage_start", 32'(stage_start), 32'(0));
      check("rst_stage_sel",   32'(stage_sel),   32'(0));
      check("rst_round_idx",   32'(round_idx),   32'(0));
      check("rst_busy",        32'(busy),        32'(0));
      check("rst_done",        32'(done),        32'(0));
      check("rst_error",       32'(error),       32'(0));

      for (int cy = 0; cy < mcyc; cy++) begin
         @(posedge clk);
         #1;
         cur = cy;
         running = 1'b1;
         rst = d_rst[cy];
         start = d_start[cy];
         clear = d_clear[cy];
         stage_done = d_done[cy];
         if (d_drop[cy]) begin
            check("pre_reset_start", 32'(stage_start), 32'(5'b01000));
            #1 rst = 1'b0;
            #1;
            check("async_rst_start", 32'(stage_start), 32'(0));
            check("async_rst_busy",  32'(busy),        32'(0));
            check("async_rst_round", 32'(round_idx),   32'(0));
            check("async_rst_sel",   32'(stage_sel),   32'(0));
         end
      end
      @(negedge clk);
      #1;
      running = 1'b0;
      stage_done = '0;
      start = 1'b0;

      check("t1_first_start",  32'(ob_start[t1 + 1]),  32'(5'b00001));
      check("t1_last_start",   32'(ob_start[t1 + 28]), 32'(5'b10000));
      check("t1_round_before", 32'(ob_round[t1 + 15]), 32'(0));
      check("t1_round_after",  32'(ob_round[t1 + 16]), 32'(1));
      check("t1_done_31",      32'(ob_done[t1 + 31]),  32'(1));
      check("t1_done_30",      32'(ob_done[t1 + 30]),  32'(0));
      check("t1_busy_31",      32'(ob_busy[t1 + 31]),  32'(0));
      check("t2_stage3_start", 32'(ob_start[t2 + 21]), 32'(5'b01000));
      check("t2_stage3_sel",   32'(ob_sel[t2 + 21]),   32'(3));
      check("t3_err_16",       32'(ob_err[t3 + 16]),   32'(0));
      check("t3_err_17",       32'(ob_err[t3 + 17]),   32'(1));
      check("t3_err_sel",      32'(ob_sel[t3 + 17]),   32'(2));
      check("t3_err_round",    32'(ob_round[t3 + 17]), 32'(0));
      check("t3_cleared",      32'(ob_err[t3 + 21]),   32'(0));
      check("t5_done_31",      32'(ob_done[t5 + 31]),  32'(1));
      check("t5_restart",      32'(ob_start[t5 + 33]), 32'(5'b00001));
      check("t6_first_start",  32'(ob_start[t6 + 1]),  32'(5'b00001));
      check("t6_done_31",      32'(ob_done[t6 + 31]),  32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
